// File: rtl/secure_serdes_decryptor_core.sv
// rtl/secure_serdes_decryptor_core.sv - serial cipher receiver, XOR decryptor and output FIFO
module secure_serdes_decryptor_core #(
   parameter logic [7:0] KEY_BYTE   = 8'h34,
   parameter int         FIFO_DEPTH = 4,
   parameter bit         CHECK_DONE = 1'b1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start,
   input  logic                            cipher_in,
   input  logic                            tx_done,
   output logic [7:0]                      out_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
   output logic                            busy,
   output logic                            frame_err,
   output logic                            overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RECV    = 2'd1,
      DECRYPT = 2'd2
   } state_t;

   state_t        state, state_next;
   logic [7:0]    shreg, shreg_next;
   logic [2:0]    bit_cnt, bit_cnt_next;
   logic          frame_err_next;
   logic          push_req;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic          full;
   logic          push, pop, drop;

   // State, shift register, bit counter and error pulse registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         shreg     <= 8'h00;
         bit_cnt   <= 3'd0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_next;
         shreg     <= shreg_next;
         bit_cnt   <= bit_cnt_next;
         frame_err <= frame_err_next;
      end
   end

   // Next-state logic: bit capture, framing check and abort on restart
   always_comb begin
      state_next     = state;
      shreg_next     = shreg;
      bit_cnt_next   = bit_cnt;
      frame_err_next = 1'b0;
      push_req       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next   = RECV;
               bit_cnt_next = 3'd0;
            end
         end
         RECV: begin
            if (start) begin
               // A new start abandons the partial byte; the next edge is bit 0
               frame_err_next = 1'b1;
               bit_cnt_next   = 3'd0;
            end else begin
               shreg_next   = {shreg[6:0], cipher_in};
               bit_cnt_next = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) begin
                  if (CHECK_DONE && !tx_done) begin
                     frame_err_next = 1'b1;
                     state_next     = IDLE;
                  end else begin
                     state_next = DECRYPT;
                  end
               end
            end
         end
         DECRYPT: begin
            push_req   = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign full = (count == CW'(FIFO_DEPTH));
   assign pop  = out_valid & out_ready;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept
   assign push = push_req & (~full | pop);
   assign drop = push_req & full & ~pop;

   // FIFO storage; only written on an accepted push
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= shreg ^ KEY_BYTE;
   end

   // FIFO pointers, occupancy and sticky overflow flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop)
            overflow <= 1'b1;
      end
   end

   assign out_valid  = (count != '0);
   // Gated so the (unreset) storage never shows through after reset
   assign out_data   = out_valid ? mem[rd_ptr] : 8'h00;
   assign fifo_count = count;
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_secure_serdes_decryptor_core.sv
// tb/tb_secure_serdes_decryptor_core.sv - directed self-checking bench for secure_serdes_decryptor_core
module tb_secure_serdes_decryptor_core;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       cipher_in;
   logic       tx_done;
   logic       out_ready;
   logic [7:0] out_data, nc_out_data;
   logic       out_valid, nc_out_valid;
   logic [2:0] fifo_count, nc_fifo_count;
   logic       busy, nc_busy;
   logic       frame_err, nc_frame_err;
   logic       overflow, nc_overflow;

   int checks = 0;
   int errors = 0;
   int fe_cnt = 0;

   always #5 clk = ~clk;

   secure_serdes_decryptor_core #(.KEY_BYTE(8'h34), .FIFO_DEPTH(4), .CHECK_DONE(1'b1)) dut (
      .clk(clk), .rst(rst), .start(start), .cipher_in(cipher_in), .tx_done(tx_done),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .fifo_count(fifo_count), .busy(busy), .frame_err(frame_err), .overflow(overflow)
   );

   secure_serdes_decryptor_core #(.KEY_BYTE(8'h34), .FIFO_DEPTH(4), .CHECK_DONE(1'b0)) dut_nc (
      .clk(clk), .rst(rst), .start(start), .cipher_in(cipher_in), .tx_done(tx_done),
      .out_data(nc_out_data), .out_valid(nc_out_valid), .out_ready(out_ready),
      .fifo_count(nc_fifo_count), .busy(nc_busy), .frame_err(nc_frame_err), .overflow(nc_overflow)
   );

   // Count frame_err pulses of the checked instance, sampled away from the active edge
   always @(negedge clk) if (frame_err === 1'b1) fe_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start pulse then 8 MSB-first bits; returns just after the 8th sample edge
   task automatic send_frame(input logic [7:0] b, input logic done);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         cipher_in = b[i];
         tx_done   = (i == 0) ? done : 1'b0;
         tick();
      end
      tx_done   = 1'b0;
      cipher_in = 1'b0;
   endtask

   initial begin
      int fe0;
      logic [7:0] exp_q [4];

      rst = 1'b1; start = 1'b0; cipher_in = 1'b0; tx_done = 1'b0; out_ready = 1'b1;
      tick(); tick();
      chk("reset_valid", out_valid, 0);
      chk("reset_count", fifo_count, 0);
      chk("reset_busy", busy, 0);
      chk("reset_ovf", overflow, 0);
      rst = 1'b0;
      tick();

      // Single frame 8'h61 -> 8'h55
      send_frame(8'h61, 1'b1);
      chk("single_busy_e8", busy, 1);
      chk("single_valid_pre_e9", out_valid, 0);
      tick();
      chk("single_valid", out_valid, 1);
      chk("single_data", out_data, 8'h55);
      chk("single_idle", busy, 0);
      tick();
      chk("single_count_drain", fifo_count, 0);

      // Framing error; CHECK_DONE=0 instance still delivers
      fe0 = fe_cnt;
      send_frame(8'h61, 1'b0);
      chk("ferr_pulse", frame_err, 1);
      chk("ferr_idle", busy, 0);
      chk("nc_no_err", nc_frame_err, 0);
      tick();
      chk("ferr_pulse_end", frame_err, 0);
      chk("ferr_no_valid", out_valid, 0);
      chk("ferr_pulse_count", fe_cnt - fe0, 1);
      chk("nc_valid", nc_out_valid, 1);
      chk("nc_data", nc_out_data, 8'h55);
      tick();

      // Backpressure and overflow
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         send_frame(8'h34 + 8'(k), 1'b1);
         tick();
      end
      chk("ovf_count", fifo_count, 4);
      chk("ovf_flag", overflow, 1);
      exp_q = '{8'h00, 8'h01, 8'h02, 8'h03};
      chk("ovf_hold", out_data, 8'h00);
      tick();
      chk("ovf_hold_stable", out_data, 8'h00);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("ovf_pop%0d", k), out_data, exp_q[k]);
         tick();
      end
      chk("ovf_empty", out_valid, 0);
      chk("ovf_sticky", overflow, 1);

      // Restart mid-frame
      fe0 = fe_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cipher_in = i[0];
         tick();
      end
      send_frame(8'hB4, 1'b1);
      tick();
      chk("restart_err_count", fe_cnt - fe0, 1);
      chk("restart_valid", out_valid, 1);
      chk("restart_data", out_data, 8'h80);
      tick();

      // Simultaneous push and pop at full (after clearing sticky overflow)
      rst = 1'b1; #1; rst = 1'b0;
      chk("rst_ovf_clear", overflow, 0);
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         send_frame(8'h34 + 8'(k), 1'b1);
         tick();
      end
      chk("full_count", fifo_count, 4);
      send_frame(8'h38, 1'b1);
      out_ready = 1'b1;
      tick();
      chk("pp_count", fifo_count, 4);
      chk("pp_no_ovf", overflow, 0);
      exp_q = '{8'h01, 8'h02, 8'h03, 8'h0C};
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("pp_pop%0d", k), out_data, exp_q[k]);
         tick();
      end
      chk("pp_empty", fifo_count, 0);

      // Asynchronous reset mid-RECV with a byte waiting in the FIFO
      out_ready = 1'b0;
      send_frame(8'h61, 1'b1);
      tick();
      chk("pre_rst_valid", out_valid, 1);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cipher_in = 1'b1;
         tick();
      end
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_valid", out_valid, 0);
      chk("arst_data", out_data, 0);
      chk("arst_count", fifo_count, 0);
      chk("arst_ferr", frame_err, 0);
      #1 rst = 1'b0;
      tick();
      out_ready = 1'b1;
      send_frame(8'h61, 1'b1);
      tick();
      chk("post_rst_data", out_data, 8'h55);
      chk("post_rst_count", fifo_count, 1);
      tick();
      chk("post_rst_drain", fifo_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
